// File: rtl/operand_fetcher_if.sv
// Memory read port and fetch-result handshake shared by the operand fetcher,
// the memory bus mux and the CPU sequencer.
interface operand_fetcher_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [7:0]            mem_rdata;

    logic                  op_valid;
    logic                  op_ready;
    logic [7:0]            opcode;
    logic [3:0]            mode;
    logic [7:0]            imm;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic                  page_cross;

    modport master (
        output mem_req, mem_addr, op_valid, opcode, mode, imm, eff_addr, page_cross,
        input  mem_ack, mem_rdata, op_ready
    );

    modport slave (
        input  mem_req, mem_addr, op_valid, opcode, mode, imm, eff_addr, page_cross,
        output mem_ack, mem_rdata, op_ready
    );
endinterface

// File: rtl/operand_fetcher.sv
// 6502 opcode/operand fetch unit: reads opcode, operands and indirect pointers, then
// presents a resolved address. OPERAND_FETCHER_JMP_BUG_EN enables the NMOS JMP (ind) page wrap.
module operand_fetcher #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] START_PC   = 16'h8000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    input  logic [7:0]            x_in,
    input  logic [7:0]            y_in,
    operand_fetcher_if.master     bus,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy
);

    localparam logic [3:0] ModeImp  = 4'd0;
    localparam logic [3:0] ModeImm  = 4'd1;
    localparam logic [3:0] ModeZpg  = 4'd2;
    localparam logic [3:0] ModeZpgX = 4'd3;
    localparam logic [3:0] ModeZpgY = 4'd4;
    localparam logic [3:0] ModeAbs  = 4'd5;
    localparam logic [3:0] ModeAbsX = 4'd6;
    localparam logic [3:0] ModeAbsY = 4'd7;
    localparam logic [3:0] ModeXInd = 4'd8;
    localparam logic [3:0] ModeIndY = 4'd9;
    localparam logic [3:0] ModeRel  = 4'd10;
    localparam logic [3:0] ModeInd  = 4'd11;

    typedef enum logic [2:0] {
        StIdle, StOpc, StOp1, StOp2, StPtrLo, StPtrHi, StDone
    } state_e;

    state_e    state_q;
    logic [7:0]  op_lo_q;
    logic [7:0]  lo_q;
    logic [15:0] ptr_q;

    logic [3:0]            dec_mode;
    logic [1:0]            cc;
    logic [2:0]            bbb;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [7:0]            zp_idx;
    logic                  op1_last;
    logic [7:0]            abs_idx;
    logic [8:0]            abs_lo;
    logic [15:0]           abs_sum;
    logic [15:0]           ind_hi_addr;
    logic [15:0]           ptr_hi_addr;
    logic [7:0]            ind_idx;
    logic [8:0]            ind_lo;
    logic [15:0]           ind_sum;
    logic [ADDR_WIDTH-1:0] rel_target;

    assign busy = (state_q != StIdle);

    always_comb begin
        cc       = bus.mem_rdata[1:0];
        bbb      = bus.mem_rdata[4:2];
        dec_mode = ModeImp;
        if (cc == 2'b01) begin
            case (bbb)
                3'd0:    dec_mode = ModeXInd;
                3'd1:    dec_mode = ModeZpg;
                3'd2:    dec_mode = ModeImm;
                3'd3:    dec_mode = ModeAbs;
                3'd4:    dec_mode = ModeIndY;
                3'd5:    dec_mode = ModeZpgX;
                3'd6:    dec_mode = ModeAbsY;
                default: dec_mode = ModeAbsX;
            endcase
        end else if (cc != 2'b11) begin
            case (bbb)
                3'd0: begin
                    if (bus.mem_rdata == 8'h20)  dec_mode = ModeAbs;
                    else if (bus.mem_rdata[7])   dec_mode = ModeImm;
                    else                         dec_mode = ModeImp;
                end
                3'd1:    dec_mode = ModeZpg;
                3'd3:    dec_mode = (bus.mem_rdata == 8'h6C) ? ModeInd : ModeAbs;
                3'd4:    dec_mode = (cc == 2'b00) ? ModeRel : ModeImp;
                3'd5:    dec_mode = (bus.mem_rdata == 8'h96 || bus.mem_rdata == 8'hB6) ?
                                    ModeZpgY : ModeZpgX;
                3'd7:    dec_mode = (bus.mem_rdata == 8'hBE) ? ModeAbsY : ModeAbsX;
                default: dec_mode = ModeImp;
            endcase
        end
    end

    always_comb begin
        pc_inc   = pc + ADDR_WIDTH'(1);
        zp_idx   = bus.mem_rdata + ((bus.mode == ModeZpgY) ? y_in : x_in);
        op1_last = (bus.mode == ModeImm) || (bus.mode == ModeZpg) || (bus.mode == ModeZpgX) ||
                   (bus.mode == ModeZpgY) || (bus.mode == ModeRel);
        rel_target = pc_inc + {{(ADDR_WIDTH-8){bus.mem_rdata[7]}}, bus.mem_rdata};

        abs_idx = (bus.mode == ModeAbsX) ? x_in : ((bus.mode == ModeAbsY) ? y_in : 8'h00);
        abs_lo  = {1'b0, op_lo_q} + {1'b0, abs_idx};
        abs_sum = {bus.mem_rdata, op_lo_q} + {8'h00, abs_idx};

`ifdef OPERAND_FETCHER_JMP_BUG_EN
        ind_hi_addr = {ptr_q[15:8], ptr_q[7:0] + 8'd1};
`else
        ind_hi_addr = ptr_q + 16'd1;
`endif
        // Zero-page pointers wrap inside page zero.
        ptr_hi_addr = (bus.mode == ModeInd) ? ind_hi_addr : {8'h00, ptr_q[7:0] + 8'd1};

        ind_idx = (bus.mode == ModeIndY) ? y_in : 8'h00;
        ind_lo  = {1'b0, lo_q} + {1'b0, ind_idx};
        ind_sum = {bus.mem_rdata, lo_q} + {8'h00, ind_idx};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            pc             <= START_PC;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.op_valid   <= 1'b0;
            bus.opcode     <= 8'h00;
            bus.mode       <= ModeImp;
            bus.imm        <= 8'h00;
            bus.eff_addr   <= '0;
            bus.page_cross <= 1'b0;
            op_lo_q        <= 8'h00;
            lo_q           <= 8'h00;
            ptr_q          <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pc_load) begin
                        pc <= pc_load_val;
                    end else if (start) begin
                        state_q      <= StOpc;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= pc;
                    end
                end
                StOpc: begin
                    if (bus.mem_ack) begin
                        pc             <= pc_inc;
                        bus.opcode     <= bus.mem_rdata;
                        bus.mode       <= dec_mode;
                        bus.imm        <= 8'h00;
                        bus.eff_addr   <= '0;
                        bus.page_cross <= 1'b0;
                        if (dec_mode == ModeImp) begin
                            state_q      <= StDone;
                            bus.mem_req  <= 1'b0;
                            bus.op_valid <= 1'b1;
                        end else begin
                            state_q      <= StOp1;
                            bus.mem_addr <= pc_inc;
                        end
                    end
                end
                StOp1: begin
                    if (bus.mem_ack) begin
                        pc <= pc_inc;
                        case (bus.mode)
                            ModeImm: bus.imm <= bus.mem_rdata;
                            ModeZpg: bus.eff_addr <= ADDR_WIDTH'(bus.mem_rdata);
                            ModeZpgX, ModeZpgY: bus.eff_addr <= ADDR_WIDTH'(zp_idx);
                            ModeRel: begin
                                bus.imm        <= bus.mem_rdata;
                                bus.eff_addr   <= rel_target;
                                bus.page_cross <= (rel_target[15:8] != pc_inc[15:8]);
                            end
                            ModeXInd: begin
                                state_q      <= StPtrLo;
                                ptr_q        <= {8'h00, zp_idx};
                                bus.mem_addr <= ADDR_WIDTH'(zp_idx);
                            end
                            ModeIndY: begin
                                state_q      <= StPtrLo;
                                ptr_q        <= {8'h00, bus.mem_rdata};
                                bus.mem_addr <= ADDR_WIDTH'(bus.mem_rdata);
                            end
                            default: begin
                                state_q      <= StOp2;
                                op_lo_q      <= bus.mem_rdata;
                                bus.mem_addr <= pc_inc;
                            end
                        endcase
                        if (op1_last) begin
                            state_q      <= StDone;
                            bus.mem_req  <= 1'b0;
                            bus.op_valid <= 1'b1;
                        end
                    end
                end
                StOp2: begin
                    if (bus.mem_ack) begin
                        pc <= pc_inc;
                        if (bus.mode == ModeInd) begin
                            state_q      <= StPtrLo;
                            ptr_q        <= {bus.mem_rdata, op_lo_q};
                            bus.mem_addr <= ADDR_WIDTH'({bus.mem_rdata, op_lo_q});
                        end else begin
                            state_q        <= StDone;
                            bus.mem_req    <= 1'b0;
                            bus.op_valid   <= 1'b1;
                            bus.eff_addr   <= ADDR_WIDTH'(abs_sum);
                            bus.page_cross <= abs_lo[8];
                        end
                    end
                end
                StPtrLo: begin
                    if (bus.mem_ack) begin
                        state_q      <= StPtrHi;
                        lo_q         <= bus.mem_rdata;
                        bus.mem_addr <= ADDR_WIDTH'(ptr_hi_addr);
                    end
                end
                StPtrHi: begin
                    if (bus.mem_ack) begin
                        state_q        <= StDone;
                        bus.mem_req    <= 1'b0;
                        bus.op_valid   <= 1'b1;
                        bus.eff_addr   <= ADDR_WIDTH'(ind_sum);
                        bus.page_cross <= ind_lo[8];
                    end
                end
                StDone: begin
                    if (bus.op_ready) begin
                        bus.op_valid <= 1'b0;
                        if (pc_load) begin
                            state_q <= StIdle;
                            pc      <= pc_load_val;
                        end else if (start) begin
                            state_q      <= StOpc;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= pc;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetcher.sv
// Directed bench for operand_fetcher: a byte-array memory with per-address stall
// injection, and hand-computed results for each addressing mode.
module tb_operand_fetcher;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [15:0] pc;
    logic        busy;
    logic        ack;
    logic        op_ready;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_log [0:255];
    logic [7:0]  rd_cnt;

    int tests;
    int fails;

    operand_fetcher_if #(.ADDR_WIDTH(16)) bus ();

    operand_fetcher #(
        .ADDR_WIDTH (16),
        .START_PC   (16'h8000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .x_in        (x_in),
        .y_in        (y_in),
        .bus         (bus),
        .pc          (pc),
        .busy        (busy)
    );

    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.mem_ack   = ack;
    assign bus.op_ready  = op_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log of every completed read address, to check pointer read order.
    always @(posedge clk) begin
        if (!reset_n) begin
            rd_cnt <= 8'd0;
        end else if (bus.mem_req && bus.mem_ack) begin
            rd_log[rd_cnt] <= bus.mem_addr;
            rd_cnt         <= rd_cnt + 8'd1;
        end
    end

    // Start a fetch, stalling st_n cycles on st_addr; cyc counts edges until op_valid.
    task automatic fetch(input logic [15:0] st_addr, input int st_n, output int cyc);
        int left;
        left = st_n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        while (bus.op_valid !== 1'b1 && cyc < 60) begin
            if (bus.mem_req && bus.mem_addr == st_addr && left > 0) begin
                ack = 1'b0;
                left--;
            end else begin
                ack = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        ack = 1'b1;
    endtask

    task automatic accept();
        @(negedge clk);
        op_ready = 1'b1;
        @(posedge clk);
        #1 op_ready = 1'b0;
    endtask

    task automatic load_pc(input logic [15:0] v);
        @(negedge clk);
        pc_load     = 1'b1;
        pc_load_val = v;
        @(posedge clk);
        #1 pc_load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (pc !== 16'h8000) begin
            fails++; $display("FAIL reset_pc: got %h expected 8000", pc);
        end
        tests++;
        if ({bus.mem_req, bus.op_valid, busy, bus.page_cross} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.mem_req, bus.op_valid, busy, bus.page_cross});
        end
        tests++;
        if ({bus.opcode, bus.imm, bus.mode} !== 20'h0) begin
            fails++;
            $display("FAIL reset_fields: got %h expected 00000", {bus.opcode, bus.imm, bus.mode});
        end
        tests++;
        if ({bus.eff_addr, bus.mem_addr} !== 32'h0) begin
            fails++;
            $display("FAIL reset_addrs: got %h expected 00000000", {bus.eff_addr, bus.mem_addr});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_imm();
        int cyc;
        mem[16'h8000] = 8'hA9;
        mem[16'h8001] = 8'h42;
        fetch(16'hFFFF, 0, cyc);
        tests++;
        if (cyc !== 3) begin fails++; $display("FAIL imm_latency: got %0d expected 3", cyc); end
        tests++;
        if ({bus.opcode, bus.mode, bus.imm} !== {8'hA9, 4'd1, 8'h42}) begin
            fails++;
            $display("FAIL imm_result: got %h/%0d/%h expected a9/1/42",
                     bus.opcode, bus.mode, bus.imm);
        end
        tests++;
        if (pc !== 16'h8002 || bus.page_cross !== 1'b0) begin
            fails++; $display("FAIL imm_pc: got %h/%b expected 8002/0", pc, bus.page_cross);
        end
        accept();
    endtask

    task automatic test_abs_x();
        int cyc;
        mem[16'h9000] = 8'hBD;
        mem[16'h9001] = 8'hFF;
        mem[16'h9002] = 8'h12;
        x_in = 8'h01;
        load_pc(16'h9000);
        fetch(16'hFFFF, 0, cyc);
        tests++;
        if (cyc !== 4) begin fails++; $display("FAIL absx_latency: got %0d expected 4", cyc); end
        tests++;
        if ({bus.mode, bus.eff_addr, bus.page_cross} !== {4'd6, 16'h1300, 1'b1}) begin
            fails++;
            $display("FAIL absx_result: got %0d/%h/%b expected 6/1300/1",
                     bus.mode, bus.eff_addr, bus.page_cross);
        end
        tests++;
        if (pc !== 16'h9003) begin fails++; $display("FAIL absx_pc: got %h expected 9003", pc); end
        accept();
        load_pc(16'h9000);
        fetch(16'h9002, 2, cyc);
        tests++;
        if (cyc !== 6) begin fails++; $display("FAIL absx_stall: got %0d expected 6", cyc); end
        tests++;
        if (bus.eff_addr !== 16'h1300) begin
            fails++; $display("FAIL absx_stall_eff: got %h expected 1300", bus.eff_addr);
        end
        accept();
    endtask

    task automatic test_x_ind();
        int cyc;
        logic [7:0] base;
        mem[16'h9100] = 8'hA1;
        mem[16'h9101] = 8'hF0;
        mem[16'h00FF] = 8'h34;
        mem[16'h0000] = 8'h12;
        x_in = 8'h0F;
        load_pc(16'h9100);
        base = rd_cnt;
        fetch(16'hFFFF, 0, cyc);
        tests++;
        if (cyc !== 5) begin fails++; $display("FAIL xind_latency: got %0d expected 5", cyc); end
        tests++;
        if ({bus.mode, bus.eff_addr, bus.page_cross} !== {4'd8, 16'h1234, 1'b0}) begin
            fails++;
            $display("FAIL xind_result: got %0d/%h/%b expected 8/1234/0",
                     bus.mode, bus.eff_addr, bus.page_cross);
        end
        tests++;
        if (rd_log[base + 8'd2] !== 16'h00FF || rd_log[base + 8'd3] !== 16'h0000) begin
            fails++;
            $display("FAIL xind_ptr_reads: got %h,%h expected 00ff,0000",
                     rd_log[base + 8'd2], rd_log[base + 8'd3]);
        end
        accept();
    endtask

    task automatic test_ind();
        int cyc;
        logic [7:0]  base;
        logic [15:0] exp_eff;
        logic [15:0] exp_hi;
`ifdef OPERAND_FETCHER_JMP_BUG_EN
        exp_eff = 16'h4000;
        exp_hi  = 16'h1000;
`else
        exp_eff = 16'h5000;
        exp_hi  = 16'h1100;
`endif
        mem[16'h9200] = 8'h6C;
        mem[16'h9201] = 8'hFF;
        mem[16'h9202] = 8'h10;
        mem[16'h10FF] = 8'h00;
        mem[16'h1000] = 8'h40;
        mem[16'h1100] = 8'h50;
        load_pc(16'h9200);
        base = rd_cnt;
        fetch(16'hFFFF, 0, cyc);
        tests++;
        if (cyc !== 6) begin fails++; $display("FAIL ind_latency: got %0d expected 6", cyc); end
        tests++;
        if ({bus.mode, bus.eff_addr} !== {4'd11, exp_eff}) begin
            fails++;
            $display("FAIL ind_result: got %0d/%h expected 11/%h", bus.mode, bus.eff_addr, exp_eff);
        end
        tests++;
        if (rd_log[base + 8'd4] !== exp_hi || pc !== 16'h9203) begin
            fails++;
            $display("FAIL ind_hi_read: got %h pc %h expected %h pc 9203",
                     rd_log[base + 8'd4], pc, exp_hi);
        end
        accept();
    endtask

    // Ends in DONE with op_ready low; the next task completes the handshake.
    task automatic test_rel_hold();
        int cyc;
        mem[16'h80FE] = 8'hD0;
        mem[16'h80FF] = 8'h80;
        load_pc(16'h80FE);
        fetch(16'hFFFF, 0, cyc);
        tests++;
        if (cyc !== 3) begin fails++; $display("FAIL rel_latency: got %0d expected 3", cyc); end
        // pc past the operand is 8100; 8100 - 80 = 8080 in the previous page.
        tests++;
        if ({bus.mode, bus.imm, bus.eff_addr, bus.page_cross, pc} !==
            {4'd10, 8'h80, 16'h8080, 1'b1, 16'h8100}) begin
            fails++;
            $display("FAIL rel_result: got %0d/%h/%h/%b/%h expected 10/80/8080/1/8100",
                     bus.mode, bus.imm, bus.eff_addr, bus.page_cross, pc);
        end
        @(negedge clk);
        start       = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({bus.op_valid, bus.opcode, bus.eff_addr, bus.page_cross, pc, bus.mem_req} !==
                {1'b1, 8'hD0, 16'h8080, 1'b1, 16'h8100, 1'b0}) begin
                fails++;
                $display("FAIL rel_hold[%0d]: got %b/%h/%h/%b/%h/%b", i, bus.op_valid,
                         bus.opcode, bus.eff_addr, bus.page_cross, pc, bus.mem_req);
            end
        end
        start   = 1'b0;
        pc_load = 1'b0;
    endtask

    task automatic test_pc_load_priority();
        @(negedge clk);
        op_ready    = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 16'hA000;
        start       = 1'b1;
        @(posedge clk);
        #1;
        op_ready = 1'b0;
        pc_load  = 1'b0;
        start    = 1'b0;
        tests++;
        if ({pc, busy, bus.op_valid} !== {16'hA000, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL load_prio: got pc %h busy %b valid %b expected a000/0/0",
                     pc, busy, bus.op_valid);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({busy, bus.mem_req} !== 2'b00) begin
            fails++; $display("FAIL load_no_fetch: got %b expected 00", {busy, bus.mem_req});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        mem[16'h9300] = 8'hEA;
        mem[16'h9301] = 8'hEA;
        load_pc(16'h9300);
        fetch(16'hFFFF, 0, cyc);
        tests++;
        if (cyc !== 2 || pc !== 16'h9301) begin
            fails++; $display("FAIL b2b_first: got %0d pc %h expected 2 pc 9301", cyc, pc);
        end
        @(negedge clk);
        op_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.op_valid, busy, bus.mem_req, bus.mem_addr} !== {3'b011, 16'h9301}) begin
            fails++;
            $display("FAIL b2b_refetch: got %b/%b/%b/%h expected 0/1/1/9301",
                     bus.op_valid, busy, bus.mem_req, bus.mem_addr);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if ({bus.op_valid, bus.opcode, pc} !== {1'b1, 8'hEA, 16'h9302}) begin
            fails++;
            $display("FAIL b2b_second: got %b/%h/%h expected 1/ea/9302",
                     bus.op_valid, bus.opcode, pc);
        end
        @(posedge clk);
        #1;
        op_ready = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_fetch();
        load_pc(16'h9100);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 ack = 1'b0;
        tests++;
        if ({bus.mem_req, busy, bus.mem_addr} !== {2'b11, 16'h00FF}) begin
            fails++;
            $display("FAIL midfetch_ptr: got %b/%b/%h expected 1/1/00ff",
                     bus.mem_req, busy, bus.mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.mem_req, busy, pc} !== {2'b00, 16'h8000}) begin
            fails++;
            $display("FAIL midfetch_reset: got %b/%b/%h expected 0/0/8000",
                     bus.mem_req, busy, pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        ack     = 1'b1;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;
        x_in        = 8'h00;
        y_in        = 8'h00;
        ack         = 1'b1;
        op_ready    = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        test_reset();
        test_imm();
        test_abs_x();
        test_x_ind();
        test_ind();
        test_rel_hold();
        test_pc_load_priority();
        test_back_to_back();
        test_reset_mid_fetch();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
